// File: rtl/cut_wrap_pkg.sv
// cut_wrap_pkg: shared FSM state type, default MISR polynomial, MISR step and LFSR tap table
package cut_wrap_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE, S_DONE} state_t;
  localparam logic [24:0] DEF_MISR_POLY = 25'h0000009;
  // Widths up to 64 are handled by computing in 64 bits and masking to w
  function automatic logic [63:0] misr_next(input logic [63:0] m, input logic [63:0] poly,
                                            input logic [63:0] d, input int w);
    logic [63:0] mask;
    mask = {64{1'b1}} >> (64 - w);
    return ((m << 1) ^ (m[w-1] ? poly : 64'd0) ^ d) & mask;
  endfunction
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00b8;
      16:      return 64'h0000_0000_0000_b400;
      32:      return 64'h0000_0000_8020_0003;
      33:      return 64'h0000_0001_0008_0000;
      64:      return 64'hd800_0000_0000_0000;
      default: return 64'h0000_0001_0008_0000;
    endcase
  endfunction
endpackage

// File: rtl/cut_misr.sv
// cut_misr: W-bit multiple-input signature register with synchronous clear and gated update
module cut_misr
  import cut_wrap_pkg::*;
#(
  parameter int W = 25,
  parameter logic [W-1:0] POLY = W'(DEF_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  logic [63:0] nxt;
  always_comb begin
    nxt = misr_next(64'(q_q), 64'(POLY), 64'(d), W);
    q_d = clr ? '0 : en ? nxt[W-1:0] : q_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/cut_signature_wrapper.sv
// cut_signature_wrapper: drives a combinational CUT, captures responses and compacts them into a MISR.
// Define LFSR_GEN_EN to source vectors from an internal LFSR instead of the in_val handshake.
module cut_signature_wrapper
  import cut_wrap_pkg::*;
#(
  parameter int IN_W = 33,
  parameter int OUT_W = 25,
  parameter int SETTLE = 2,
  parameter int CNT_W = 16,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [IN_W-1:0]  in_val,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IN_W-1:0]  cut_in,
  input  logic [OUT_W-1:0] cut_out,
  output logic [OUT_W-1:0] out_val,
  output logic             out_valid,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count,
  output logic             done
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  state_t state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d, pat_q, pat_d;
  logic [IN_W-1:0] cut_in_q, cut_in_d, vec;
  logic [OUT_W-1:0] out_val_q, out_val_d;
  logic out_valid_q, out_valid_d, done_q, done_d, misr_clr, misr_en, accept, start_ok;
  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
`ifdef LFSR_GEN_EN
  localparam logic [63:0] TAPS64 = lfsr_taps(IN_W);
  localparam logic [IN_W-1:0] TAPS = TAPS64[IN_W-1:0];
  logic [IN_W-1:0] lfsr_q, lfsr_d;
  assign accept = state_q == S_LOAD;
  assign vec = lfsr_q;
  assign in_ready = 1'b0;
  always_comb begin
    lfsr_d = lfsr_q;
    if (enable && start_ok) lfsr_d = (in_val == '0) ? IN_W'(1) : in_val;
    else if (enable && accept) lfsr_d = {lfsr_q[IN_W-2:0], ^(lfsr_q & TAPS)};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= '0;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign accept = state_q == S_LOAD && in_valid;
  assign vec = in_val;
  assign in_ready = enable && state_q == S_LOAD;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    num_d = num_q;
    pat_d = pat_q;
    cut_in_d = cut_in_q;
    out_val_d = out_val_q;
    out_valid_d = 1'b0;
    done_d = done_q;
    misr_clr = 1'b0;
    misr_en = 1'b0;
    if (enable) begin
      if (start_ok) begin
        num_d = num_patterns;
        pat_d = '0;
        done_d = num_patterns == '0;
        state_d = done_d ? S_DONE : S_LOAD;
        misr_clr = 1'b1;
      end else if (accept) begin
        cut_in_d = vec;
        cnt_d = SW'(SETTLE - 1);
        state_d = S_SETTLE;
      end else if (state_q == S_SETTLE) begin
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_CAPTURE : S_SETTLE;
      end else if (state_q == S_CAPTURE) begin
        out_val_d = cut_out;
        out_valid_d = 1'b1;
        misr_en = 1'b1;
        pat_d = pat_q + 1'b1;
        done_d = pat_d == num_q;
        state_d = done_d ? S_DONE : S_LOAD;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      num_q <= '0;
      pat_q <= '0;
      cut_in_q <= '0;
      out_val_q <= '0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      pat_q <= pat_d;
      cut_in_q <= cut_in_d;
      out_val_q <= out_val_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
    end
  end
  cut_misr #(.W(OUT_W), .POLY(MISR_POLY)) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (misr_clr),
    .en   (misr_en),
    .d    (cut_out),
    .q    (signature)
  );
  assign cut_in = cut_in_q;
  assign out_val = out_val_q;
  assign out_valid = out_valid_q;
  assign pat_count = pat_q;
  assign done = done_q;
endmodule
